iterative_multdiv: RTL and testbench
====================================

# iterative_multdiv

Sequential 32-bit signed multiply/divide unit: the responder side of the processor's execute-stage `ctrl_MULT`/`ctrl_DIV` start-pulse / `data_resultRDY` handshake. The processor raises a one-cycle start pulse with operands on its ALU input buses and stalls its pipeline. This block latches the operands, iterates, then returns the result, an overflow/exception flag, and a one-cycle ready strobe that releases the stall.

## Interface
- (no parameters) — all datapath widths are fixed at 32 bits by the processor interface.
- `clock`  in  1  master clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; state clears while `reset==0`.
- `data_operandA`  in  32  multiplicand / dividend, two's complement; sampled only on a start edge.
- `data_operandB`  in  32  multiplier / divisor, two's complement; sampled only on a start edge.
- `ctrl_MULT`  in  1  start-multiply pulse, one cycle.
- `ctrl_DIV`  in  1  start-divide pulse, one cycle.
- `data_result`  out  32  low 32 bits of the product, or the quotient.
- `data_exception`  out  1  multiply overflow, divide-by-zero, or INT_MIN/−1.
- `data_resultRDY`  out  1  result-valid strobe, high for exactly one cycle per completed operation.

## Operation
- **States:** IDLE, MULT, DIV, FIX, DONE.
- **Start condition:** the start edge E0 is any rising edge with `ctrl_MULT | ctrl_DIV` high.
  - At E0, latch both operands, clear the counter, and enter MULT or DIV.
  - If both control inputs are high, `ctrl_MULT` wins.
- **Restart:** a start pulse in any state (including MULT, DIV, FIX, DONE) aborts the in-flight operation and restarts with the new operands. The aborted operation never asserts RDY.
- **MULT:** radix-4 modified Booth over a 66-bit {product, multiplier, guard} register, 16 iterations.
  - Each step adds 0, ±A or ±2A to the upper half, then arithmetic-shifts right by 2.
  - Leave MULT for FIX when the 4-bit counter hits 15.
- **DIV:** non-restoring division on operand magnitudes, with a 33-bit remainder, 32 iterations.
  - Leave DIV for FIX when the 5-bit counter hits 31.
  - Record quotient sign = A[31]^B[31] at E0.
- **FIX:** one cycle that registers `data_result` and `data_exception`, then moves to DONE.
  - MULT: `data_result` = product[31:0].
  - MULT: `data_exception` = 1 iff product[63:32] is not all copies of product[31].
  - DIV: negate the quotient if the recorded sign is 1 (truncation toward zero).
  - DIV, B==0: `data_result`=0, `data_exception`=1.
  - DIV, A==0x80000000 and B==0xFFFFFFFF: `data_result`=0x80000000, `data_exception`=1.
  - DIV, all other cases: `data_exception`=0.
- **DONE:** `data_resultRDY`=1 for one cycle, then return to IDLE.
- **Output hold:** `data_result` and `data_exception` hold their values after DONE until the next FIX or reset.
- **Remainder:** not exported.

## Timing
- **Reset values:** with `reset` low, state=IDLE, counter=0, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, operand registers=0. This takes effect immediately, independent of `clock`.
- **Reset mid-operation:** discards the operation. After release, no RDY occurs until a fresh start pulse.
- **Multiply latency:** E1..E16 are Booth steps and E17 is FIX→DONE. `data_resultRDY` is high from E17 to E18.
- **Divide latency:** E1..E32 are steps and E33 is FIX→DONE. `data_resultRDY` is high from E33 to E34.
- **Output stability:** `data_result` and `data_exception` are valid no later than the edge that raises `data_resultRDY` and remain stable while it is high.
- **Operand inputs:** ignored on every edge except a start edge. Operands may change freely during iteration.
- **Back-to-back:** a start pulse coinciding with the DONE cycle restarts normally; RDY for the completed operation still shows in that cycle.
- **Pulse length:** `ctrl_*` held high for multiple cycles restarts every cycle. The processor guarantees single-cycle pulses.

## Test plan
- **Multiply:** A=7, B=−3 (0xFFFFFFFD), `ctrl_MULT` at E0.
  - RDY high only between E17 and E18.
  - `data_result`=0xFFFFFFEB, `data_exception`=0.
- **Multiply overflow:** A=0x00010000, B=0x00010000.
  - `data_result`=0x00000000, `data_exception`=1 at E17.
  - A second case, A=0x7FFFFFFF, B=−1: result 0x80000001, `data_exception`=0.
- **Divide:** A=−7, B=2, `ctrl_DIV`.
  - RDY only at E33–E34, `data_result`=0xFFFFFFFD (−3), `data_exception`=0.
  - A second case, A=100, B=7: result 14.
- **Divide corner cases:**
  - B=0 with A=5 gives `data_result`=0, `data_exception`=1.
  - A=0x80000000, B=−1 gives `data_result`=0x80000000, `data_exception`=1.
- **Restart:** start divide 100/7, then issue `ctrl_MULT` with A=3, B=4 at E10.
  - No RDY at the original E33.
  - RDY exactly 17 edges after the restart, `data_result`=12.
- **Reset mid-operation:** drive `reset` low asynchronously (between edges) at E5 of a multiply.
  - All outputs read 0 immediately.
  - After release, no RDY ever appears without a new start pulse.
  - A subsequent 6×6 multiply returns 36 at E17.

Source files
------------

// File: rtl/iterative_multdiv_if.sv
// Execute-stage multiply/divide handshake bundle.
// The processor side is master; the iterative unit is slave.
interface iterative_multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/iterative_multdiv.sv
// Sequential 32-bit signed multiplier (radix-4 Booth) and
// non-restoring divider with a start-pulse / ready-strobe handshake.
module iterative_multdiv (
    input logic               clock,
    input logic               reset,
    iterative_multdiv_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, MULT, DIV, FIX, DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        is_div;
    logic [65:0] prod;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dmag;
    logic        qsign;
    logic [31:0] result;
    logic        exception;

    logic        start;
    logic [33:0] a_ext;
    logic [33:0] pp;
    logic [33:0] sum;
    logic [32:0] rem_shift;
    logic [32:0] rem_next;
    logic [63:0] product;
    logic [31:0] quo_signed;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.data_result = result;
    assign bus.data_exception = exception;

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = bus.ctrl_MULT ? MULT : DIV;
        end else begin
            unique case (state)
                IDLE: state_next = IDLE;
                MULT: if (cnt[3:0] == 4'd15) state_next = FIX;
                DIV:  if (cnt == 5'd31) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Upper half needs 34 bits only transiently: the sum can exceed
    // 33 bits but always fits again after the 2-bit arithmetic shift.
    always_comb begin
        a_ext = {{2{a_reg[31]}}, a_reg};
        unique case (prod[2:0])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        sum = {prod[65], prod[65:33]} + pp;
    end

    assign product = prod[64:1];
    assign rem_shift = {rem[31:0], quo[31]};
    assign rem_next = rem[32] ? rem_shift + {1'b0, dmag}
                              : rem_shift - {1'b0, dmag};
    assign quo_signed = qsign ? -quo : quo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            is_div    <= 1'b0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            dmag      <= '0;
            qsign     <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            a_reg  <= bus.data_operandA;
            b_reg  <= bus.data_operandB;
            is_div <= ~bus.ctrl_MULT;
            prod   <= {33'b0, bus.data_operandB, 1'b0};
            rem    <= '0;
            quo    <= bus.data_operandA[31] ? -bus.data_operandA
                                            : bus.data_operandA;
            dmag   <= bus.data_operandB[31] ? -bus.data_operandB
                                            : bus.data_operandB;
            qsign  <= bus.data_operandA[31] ^ bus.data_operandB[31];
        end else begin
            unique case (state)
                MULT: begin
                    prod <= {sum[33], sum, prod[32:2]};
                    cnt  <= cnt + 5'd1;
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= {quo[30:0], ~rem_next[32]};
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    if (!is_div) begin
                        result    <= product[31:0];
                        exception <= product[63:32] != {32{product[31]}};
                    end else if (b_reg == 32'd0) begin
                        result    <= 32'd0;
                        exception <= 1'b1;
                    end else if (a_reg == 32'h8000_0000 &&
                                 b_reg == 32'hFFFF_FFFF) begin
                        result    <= 32'h8000_0000;
                        exception <= 1'b1;
                    end else begin
                        result    <= quo_signed;
                        exception <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_multdiv.sv
// Self-checking bench for iterative_multdiv: vector table,
// restart and asynchronous mid-operation reset sequences.
module tb_iterative_multdiv;
    logic clock;
    logic reset;

    iterative_multdiv_if bus();

    iterative_multdiv dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks;
    int   errors;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input logic exc);
        exp_t e;
        e.res = res;
        e.exc = exc;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge following the start edge E0.
    task automatic drive_start(input bit is_div, input logic [31:0] a,
                               input logic [31:0] b);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT = !is_div;
        bus.ctrl_DIV = is_div;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Waits for RDY, checks latency in edges since E0, pops scoreboard.
    task automatic collect(input string tag, input int lat);
        int   n;
        bit   seen;
        exp_t e;
        n = 0;
        seen = 0;
        while (!seen && n < lat + 10) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (bus.data_resultRDY) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no rdy, expected rdy at %0d",
                     tag, lat);
            void'(exp_q.pop_front());
            return;
        end
        check({tag, "_latency"}, n, lat);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got rdy, expected none", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, bus.data_result, e.res);
            check({tag, "_exception"}, {31'b0, bus.data_exception},
                  {31'b0, e.exc});
        end
        @(posedge clock);
        @(negedge clock);
        check({tag, "_rdy_one_cycle"}, {31'b0, bus.data_resultRDY}, 0);
    endtask

    initial begin
        int rdy_count;
        checks = 0;
        errors = 0;
        vecs.push_back('{0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0});
        vecs.push_back('{0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1});
        vecs.push_back('{0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 0});
        vecs.push_back('{0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1});
        vecs.push_back('{0, 32'd12345, 32'hFFFF_E57B, 32'hFB01_2863, 0});
        vecs.push_back('{1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0});
        vecs.push_back('{1, 32'd100, 32'd7, 32'd14, 0});
        vecs.push_back('{1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 0});
        vecs.push_back('{1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0});
        vecs.push_back('{1, 32'h8000_0000, 32'd2, 32'hC000_0000, 0});
        vecs.push_back('{1, 32'd5, 32'd0, 32'd0, 1});
        vecs.push_back('{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});

        reset = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        #3;
        check("reset_result", bus.data_result, 0);
        check("reset_exception", {31'b0, bus.data_exception}, 0);
        check("reset_rdy", {31'b0, bus.data_resultRDY}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive_start(vecs[i].is_div, vecs[i].a, vecs[i].b);
            push_exp(vecs[i].res, vecs[i].exc);
            collect($sformatf("vec%0d", i), vecs[i].is_div ? 33 : 17);
        end

        // Divide aborted by a multiply issued at its E10.
        drive_start(1, 32'd100, 32'd7);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("restart_pre_rdy", {31'b0, bus.data_resultRDY}, 0);
        end
        drive_start(0, 32'd3, 32'd4);
        push_exp(32'd12, 1'b0);
        collect("restart", 17);
        rdy_count = 0;
        repeat (12) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.data_resultRDY) rdy_count++;
        end
        check("restart_no_stale_rdy", rdy_count, 0);

        // Asynchronous reset between E5 and E6 of a multiply.
        drive_start(0, 32'h0001_0000, 32'h0001_0000);
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_result", bus.data_result, 0);
        check("midrst_exception", {31'b0, bus.data_exception}, 0);
        check("midrst_rdy", {31'b0, bus.data_resultRDY}, 0);
        @(negedge clock);
        reset = 1'b1;
        rdy_count = 0;
        repeat (40) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.data_resultRDY) rdy_count++;
        end
        check("midrst_no_rdy", rdy_count, 0);
        drive_start(0, 32'd6, 32'd6);
        push_exp(32'd36, 1'b0);
        collect("after_reset", 17);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
